// File: rtl/gmii_rx_writer.sv
// gmii_rx_writer
//   Samples the GMII receive bus (synchronous to sys_clk), strips preamble/SFD and
//   writes frame bytes into the 18-bit phy FIFO. Every accepted frame is closed by a
//   single status/gap entry (bit 8 = 0) that delimits frames for the reader.
//
//   Entry formats:
//     data : {8'b0, last, 1'b1, byte}
//     gap  : {5'b0, fcs_err, trunc, rx_er, 2'b0, 8'h00}
//
//   Ports:
//     sys_clk, sys_rst_n  clock (rising edge) and asynchronous active-low reset
//     rx_enable           accept new frames; looked at only when the SFD is seen
//     gmii_rx_dv/er/rxd   GMII receive bus
//     phy_din, phy_wr_en  FIFO write data and strobe (registered)
//     phy_full            FIFO full; no write is issued while high
//     frame_cnt           frames fully written including the gap entry (wraps)
//     drop_cnt            frames rejected or truncated by full/disable (wraps)
//
//   Build option: define RX_FCS_CHECK_EN to run CRC-32 over the data bytes (FCS
//   included) and report a bad residue in the gap entry's fcs_err bit. Without it,
//   fcs_err is tied to 0.
module gmii_rx_writer #(
    parameter int unsigned MAX_FRAME = 1518,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             rx_enable,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    input  logic [7:0]       gmii_rxd,
    output logic [17:0]      phy_din,
    output logic             phy_wr_en,
    input  logic             phy_full,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int unsigned     LenW   = $clog2(MAX_FRAME + 1);
    localparam logic [LenW-1:0] MaxLen = LenW'(MAX_FRAME);

    typedef enum logic [2:0] {
        StIdle,
        StPream,
        StData,
        StGap,
        StDrop
    } state_e;

    state_e           state_q;
    logic [7:0]       hold_q;
    logic             hold_vld_q;
    logic [LenW-1:0]  byte_cnt_q;
    logic             trunc_q;
    logic             er_q;
    logic             dv_q;
    logic             new_frame_q;
    logic [17:0]      din_q;
    logic             wr_en_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] drop_cnt_q;

    logic dv_rise;
    logic sfd_seen;
    logic byte_accept;
    logic fcs_err;

    assign dv_rise  = gmii_rx_dv & ~dv_q;
    assign sfd_seen = (state_q == StPream) & gmii_rx_dv & (gmii_rxd == 8'hD5);
    // A byte enters the holding register only while the frame is still healthy and short.
    assign byte_accept = (state_q == StData) & gmii_rx_dv & ~trunc_q & ~phy_full &
                         (byte_cnt_q != MaxLen);

`ifdef RX_FCS_CHECK_EN
    logic [31:0] crc_q;

    // Reflected CRC-32 (poly 04C11DB7), one byte LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            crc_q <= 32'hFFFF_FFFF;
        end else if (sfd_seen) begin
            crc_q <= 32'hFFFF_FFFF;
        end else if (byte_accept) begin
            crc_q <= crc_next(crc_q, gmii_rxd);
        end
    end

    // DEBB20E3 is the residue C704DD7B seen in the reflected register's bit order.
    assign fcs_err = (crc_q != 32'hDEBB_20E3);
`else
    assign fcs_err = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            byte_cnt_q  <= '0;
            trunc_q     <= 1'b0;
            er_q        <= 1'b0;
            // Treat dv as already high so a frame in flight at release is ignored.
            dv_q        <= 1'b1;
            new_frame_q <= 1'b0;
            din_q       <= '0;
            wr_en_q     <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            dv_q    <= gmii_rx_dv;
            wr_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (gmii_rx_dv) begin
                        state_q <= (dv_rise && gmii_rxd == 8'h55) ? StPream : StDrop;
                    end
                end

                StPream: begin
                    if (!gmii_rx_dv) begin
                        state_q <= StIdle;
                    end else if (sfd_seen) begin
                        if (rx_enable) begin
                            state_q    <= StData;
                            hold_vld_q <= 1'b0;
                            byte_cnt_q <= '0;
                            trunc_q    <= 1'b0;
                            er_q       <= 1'b0;
                        end else begin
                            state_q    <= StDrop;
                            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
                        end
                    end else if (gmii_rxd != 8'h55) begin
                        state_q <= StDrop;
                    end
                end

                StData: begin
                    new_frame_q <= 1'b0;
                    if (gmii_rx_er) begin
                        er_q <= 1'b1;
                    end
                    if (gmii_rx_dv) begin
                        if (byte_accept) begin
                            if (hold_vld_q) begin
                                din_q   <= {8'h00, 1'b0, 1'b1, hold_q};
                                wr_en_q <= 1'b1;
                            end
                            hold_q     <= gmii_rxd;
                            hold_vld_q <= 1'b1;
                            byte_cnt_q <= byte_cnt_q + LenW'(1);
                        end else if (!trunc_q) begin
                            if (phy_full) begin
                                // Abandon the rest of the frame; held byte is lost too.
                                trunc_q    <= 1'b1;
                                hold_vld_q <= 1'b0;
                                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
                                state_q    <= StGap;
                            end else begin
                                // Byte MAX_FRAME+1: close out with byte MAX_FRAME as last.
                                din_q      <= {8'h00, 1'b1, 1'b1, hold_q};
                                wr_en_q    <= 1'b1;
                                hold_vld_q <= 1'b0;
                                trunc_q    <= 1'b1;
                            end
                        end
                    end else begin
                        state_q    <= StGap;
                        hold_vld_q <= 1'b0;
                        if (hold_vld_q) begin
                            if (phy_full) begin
                                trunc_q    <= 1'b1;
                                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
                            end else begin
                                din_q   <= {8'h00, 1'b1, 1'b1, hold_q};
                                wr_en_q <= 1'b1;
                            end
                        end
                    end
                end

                StGap: begin
                    if (dv_rise) begin
                        new_frame_q <= 1'b1;
                    end
                    if (!phy_full) begin
                        din_q       <= {5'b0_0000, fcs_err, trunc_q, er_q, 2'b00, 8'h00};
                        wr_en_q     <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                        state_q     <= gmii_rx_dv ? StDrop : StIdle;
                        // A frame that began while we were still closing the last one is lost.
                        if (new_frame_q || dv_rise) begin
                            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
                        end
                    end
                end

                StDrop: begin
                    if (!gmii_rx_dv) begin
                        state_q <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign phy_din   = din_q;
    assign phy_wr_en = wr_en_q;
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_gmii_rx_writer.sv
// tb_gmii_rx_writer
//   Drives GMII frames (directed and $urandom) into gmii_rx_writer and compares the
//   FIFO write stream and counters with a frame-level reference model.
module tb_gmii_rx_writer;

    localparam int MaxFrame = 1518;
`ifdef RX_FCS_CHECK_EN
    localparam bit FcsEn = 1'b1;
`else
    localparam bit FcsEn = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        rx_enable;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  gmii_rxd;
    logic [17:0] phy_din;
    logic        phy_wr_en;
    logic        phy_full;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    int exp_drops = 0;
    logic [17:0] got_q[$];
    logic [17:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;

    gmii_rx_writer #(
        .MAX_FRAME(MaxFrame),
        .CNT_W    (16)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_enable (rx_enable),
        .gmii_rx_dv(gmii_rx_dv),
        .gmii_rx_er(gmii_rx_er),
        .gmii_rxd  (gmii_rxd),
        .phy_din   (phy_din),
        .phy_wr_en (phy_wr_en),
        .phy_full  (phy_full),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
    );

    always @(negedge sys_clk) begin
        if (sys_rst_n === 1'b1 && phy_wr_en === 1'b1) got_q.push_back(phy_din);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic dv, input logic er, input logic [7:0] d, input logic en,
                       input logic full);
        @(posedge sys_clk);
        #1;
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        gmii_rxd   = d;
        rx_enable  = en;
        phy_full   = full;
    endtask

    // Standard Ethernet FCS of the first n bytes.
    function automatic logic [31:0] fcs_of(input bq_t d, input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, d[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    // True unless the last four of the first k bytes are the FCS of the bytes before them.
    function automatic bit fcs_bad(input bq_t d, input int k);
        if (k < 4) return 1'b1;
        return fcs_of(d, k - 4) != {d[k-1], d[k-2], d[k-3], d[k-4]};
    endfunction

    function automatic bq_t mk_frame(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic bq_t with_fcs(input bq_t p);
        bq_t q = p;
        logic [31:0] f = fcs_of(p, p.size());
        q.push_back(f[7:0]);
        q.push_back(f[15:8]);
        q.push_back(f[23:16]);
        q.push_back(f[31:24]);
        return q;
    endfunction

    // Expected FIFO entries and counter effects of one frame.
    task automatic model_frame(input bq_t d, input int er_idx, input int full_at, input bit en);
        int n = d.size();
        int k;
        bit trunc, er, fe;
        if (!en) begin
            exp_drops++;
            return;
        end
        if (full_at >= 0) begin
            // The byte held when full appears and everything after it is lost.
            for (int i = 0; i < full_at - 1; i++) exp_q.push_back({8'h00, 2'b01, d[i]});
            trunc = 1'b1;
            er    = (er_idx >= 0) && (er_idx <= full_at);
            k     = full_at;
            exp_drops++;
        end else begin
            k = (n > MaxFrame) ? MaxFrame : n;
            for (int i = 0; i < k; i++) exp_q.push_back({8'h00, (i == k - 1), 1'b1, d[i]});
            trunc = (n > MaxFrame);
            er    = (er_idx >= 0) && (er_idx < n);
        end
        fe = FcsEn && fcs_bad(d, k);
        exp_q.push_back({5'b0, fe, trunc, er, 10'h000});
        exp_frames++;
    endtask

    task automatic send_frame(input bq_t d, input int er_idx, input int full_at,
                              input int full_len, input bit en, input int idle,
                              input bit base_full);
        int n = d.size();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, (i == 7) ? 8'hD5 : 8'h55, en, base_full);
        for (int i = 0; i < n + idle; i++) begin
            logic f;
            f = base_full | (full_at >= 0 && i >= full_at && i < full_at + full_len);
            if (i < n) cyc(1'b1, (i == er_idx), d[i], 1'($urandom_range(0, 1)), f);
            else       cyc(1'b0, 1'b0, 8'h00, 1'($urandom_range(0, 1)), f);
        end
    endtask

    task automatic compare_frame(input string tag);
        check({tag, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, " entry"}, {14'h0, got_q[i]}, {14'h0, exp_q[i]});
        end
        check({tag, " frame_cnt"}, {16'h0, frame_cnt}, exp_frames & 32'hFFFF);
        check({tag, " drop_cnt"}, {16'h0, drop_cnt}, exp_drops & 32'hFFFF);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic run(input string tag, input bq_t d, input int er_idx, input int full_at,
                       input int full_len, input bit en);
        model_frame(d, er_idx, full_at, en);
        send_frame(d, er_idx, full_at, full_len, en, 12, 1'b0);
        compare_frame(tag);
    endtask

    initial begin
        bq_t d, e;
        int  n, er_idx, full_at, flen;
        bit  en;

        sys_rst_n  = 1'b0;
        rx_enable  = 1'b1;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        gmii_rxd   = 8'h00;
        phy_full   = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("reset phy_din", {14'h0, phy_din}, 32'h0);
        check("reset wr_en", {31'h0, phy_wr_en}, 32'h0);
        check("reset frame_cnt", {16'h0, frame_cnt}, 32'h0);
        check("reset drop_cnt", {16'h0, drop_cnt}, 32'h0);
        #1 sys_rst_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Counting frame, back-pressure truncation, disable at SFD, rx_er.
        d.delete();
        for (int i = 0; i < 64; i++) d.push_back(8'(i));
        run("t1 basic", d, -1, -1, 0, 1'b1);
        run("t2 full", d, -1, 10, 5, 1'b1);
        run("t3 disabled", mk_frame(40), -1, -1, 0, 1'b0);
        run("t3 enabled", mk_frame(40), -1, -1, 0, 1'b1);
        run("t4 rx_er", mk_frame(60), 20, -1, 0, 1'b1);

        // FCS good and with one bit flipped.
        d = with_fcs(mk_frame(60));
        run("t5 fcs ok", d, -1, -1, 0, 1'b1);
        d[62] = d[62] ^ 8'h10;
        run("t5 fcs bad", d, -1, -1, 0, 1'b1);

        // Length boundaries.
        run("zero bytes", d[0:-1], -1, -1, 0, 1'b1);
        run("max exact", mk_frame(MaxFrame), -1, -1, 0, 1'b1);
        run("max over", mk_frame(MaxFrame + 2), MaxFrame + 1, -1, 0, 1'b1);

        // A frame arriving while the previous gap entry is blocked by full.
        d = mk_frame(20);
        e = mk_frame(12);
        model_frame(d, -1, -1, 1'b1);
        exp_drops++;
        send_frame(d, -1, -1, 0, 1'b1, 1, 1'b0);
        send_frame(e, -1, -1, 0, 1'b1, 4, 1'b1);
        repeat (10) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        compare_frame("gap full");

        for (int t = 0; t < 30; t++) begin
            d = mk_frame($urandom_range(0, 70));
            if ($urandom_range(0, 1) == 1) d = with_fcs(d);
            n = d.size();
            er_idx  = -1;
            full_at = -1;
            if (n > 0 && $urandom_range(0, 3) == 0) er_idx = $urandom_range(0, n - 1);
            if (n >= 2 && $urandom_range(0, 3) == 0) full_at = $urandom_range(1, n - 1);
            flen = $urandom_range(1, 5);
            en   = ($urandom_range(0, 7) != 0);
            run("random", d, er_idx, full_at, flen, en);
        end

        // Reset in mid-frame, with a fake preamble after release that must be ignored.
        d = mk_frame(64);
        for (int i = 33; i < 40; i++) d[i] = 8'h55;
        d[40] = 8'hD5;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, (i == 7) ? 8'hD5 : 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) begin
            cyc(1'b1, 1'b0, d[i], 1'b1, 1'b0);
            if (i == 30) begin
                sys_rst_n = 1'b0;
                got_q.delete();
                exp_q.delete();
                exp_frames = 0;
                exp_drops  = 0;
            end
            if (i == 31) begin
                @(negedge sys_clk);
                check("t6 rst phy_din", {14'h0, phy_din}, 32'h0);
                check("t6 rst wr_en", {31'h0, phy_wr_en}, 32'h0);
                check("t6 rst frame_cnt", {16'h0, frame_cnt}, 32'h0);
                check("t6 rst drop_cnt", {16'h0, drop_cnt}, 32'h0);
            end
            if (i == 32) sys_rst_n = 1'b1;
        end
        repeat (8) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        compare_frame("t6 after reset");
        run("t6 next frame", mk_frame(50), -1, -1, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
